audio_sample_feeder: RTL
========================

// Module: audio_sample_feeder
// PURPOSE
//  Sits between the synth waveform generator (7-bit unsigned wave) and the Audio_Controller
//  output FIFO. Samples wave_in at the codec rate and converts it to a 32-bit signed
//  two's-complement sample. Buffers samples in a small FIFO and writes them to the
//  controller via the write_audio_out / audio_out_allowed handshake. Output is mono,
//  with the same sample driven on both left and right channels.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  SAMPLE_HZ   48_000      sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer, 1041 at defaults)
//  IN_W        7           wave_in width (unsigned, midpoint 2**(IN_W-1))
//  OUT_W       32          audio sample width
//  FIFO_DEPTH  8           sample buffer entries (power of 2, >=2)
// PORTS
//  clock                  in   1      system clock (50 MHz)
//  reset                  in   1      synchronous, active-high reset
//  enable                 in   1      1 = capture samples; 0 = no captures, FIFO keeps draining
//  wave_in                in   IN_W   unsigned waveform from the synth ALU controller
//  volume                 in   3      attenuation select (only when AUDIO_FEEDER_VOLUME_EN is defined)
//  audio_out_allowed      in   1      from Audio_Controller: space available in its output FIFO
//  write_audio_out        out  1      write strobe to Audio_Controller, 1 cycle per sample
//  left_channel_audio_out out  OUT_W  sample data, valid while write_audio_out=1
//  right_channel_audio_out out OUT_W  identical to left
//  overflow               out  1      sticky: a captured sample was dropped because the FIFO was full
//  fifo_level             out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (sync, on the cycle reset=1): tick counter=0, FIFO empty, FSM=IDLE,
//    write_audio_out=0, channel outputs=0, overflow=0, fifo_level=0. Reset mid-write aborts
//    the write; no strobe is issued in the following cycle.
//  - Tick: counter counts 0..DIV-1 and wraps. tick=1 in the cycle counter==DIV-1 and enable=1.
//    The counter runs regardless of enable.
//  - Capture on tick: s = {1'b0,wave_in} - 2**(IN_W-1), giving a signed range of -64..63.
//    sample = s <<< (OUT_W-IN_W): s occupies the top IN_W bits, all lower bits are 0.
//    The sample is pushed into the FIFO one cycle after the tick.
//  - FIFO full on push: sample dropped, overflow set (clears only on reset), contents unchanged.
//  - Push and pop in the same cycle: both are performed; level is unchanged. Push on a full FIFO
//    is still dropped, even if a pop occurs that cycle.
//  - Drain FSM:
//    IDLE  -> WRITE when FIFO non-empty and audio_out_allowed=1.
//    WRITE: write_audio_out=1 for exactly one cycle; channel outputs = FIFO head; pop the head.
//           -> GAP.
//    GAP:   write_audio_out=0 for one cycle, so the controller can update
//           audio_out_allowed. -> IDLE.
//    Throughput is at most 1 sample per 3 cycles, well above the sample rate.
//    audio_out_allowed is sampled only in IDLE; dropping it during WRITE does not cancel the write.
//  - Channel outputs hold their last written value outside WRITE.
//  - Latency: tick -> earliest write_audio_out = 3 cycles (push, IDLE decision, WRITE).
// CONFIGURATION
//  AUDIO_FEEDER_VOLUME_EN defined:
//    - volume port exists.
//    - After the shift, sample is arithmetically shifted right by (7-volume):
//      volume=7 gives unity gain; volume=0 gives /128.
//    - volume is captured on the same tick as wave_in.
//  AUDIO_FEEDER_VOLUME_EN undefined:
//    - volume port absent; unity gain.
// STRUCTURE
//  - Package audio_feeder_pkg: FSM state encoding (IDLE, WRITE, GAP), default rates,
//    MIDPOINT constant, and function to_sample(wave, volume).
//  - Sub-module sample_fifo: synchronous single-clock FIFO with DATA_W and DEPTH parameters;
//    ports push, pop, din, dout (head, show-ahead), full, empty, level.
//  - Top level: tick divider, conversion register, drain FSM.
// TESTING
//  1. Reset, then wave_in=64, allowed=1, enable=1 -> first strobe 3 cycles after tick,
//     data=32'h0000_0000 on L and R.
//  2. wave_in=127, then wave_in=0 on consecutive ticks -> strobes spaced DIV cycles apart,
//     data 32'h7E00_0000 then 32'h8000_0000.
//  3. Hold allowed=0 for 9 ticks (FIFO_DEPTH=8) -> fifo_level=8, overflow=1. Release allowed ->
//     exactly 8 strobes, 3 cycles apart, in capture order.
//  4. Deassert allowed in the cycle after IDLE->WRITE -> the write still completes; no further
//     strobe until allowed=1.
//  5. Assert reset during WRITE with level=3 -> next cycle strobe=0, level=0, overflow=0,
//     outputs=0.
//  6. (VOLUME_EN) wave_in=127, volume=5 -> data=32'h1F80_0000. volume=7 -> data=32'h7E00_0000.

Source files
------------

// File: rtl/audio_feeder_pkg.sv
// Shared types, default rates and sample conversion for the audio sample feeder.
// Volume attenuation is compiled in only when AUDIO_FEEDER_VOLUME_EN is defined.
package audio_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP
  } state_t;

  localparam int CLK_HZ_DEF    = 50_000_000;
  localparam int SAMPLE_HZ_DEF = 48_000;
  localparam int IN_W_DEF      = 7;
  localparam int OUT_W_DEF     = 32;
  localparam int MIDPOINT      = 2 ** (IN_W_DEF - 1);

  // Recentre, left-justify into out_w bits, then attenuate by (7-vol).
  function automatic logic [63:0] to_sample(
    input logic [15:0] wave,
    input logic [2:0]  vol,
    input int          in_w,
    input int          out_w
  );
    logic signed [63:0] s;
    s = $signed({48'd0, wave}) - (64'sd1 <<< (in_w - 1));
    s = s <<< (out_w - in_w);
    s = s >>> (3'd7 - vol);
    return s;
  endfunction

endpackage

// File: rtl/audio_sample_feeder_fifo.sv
// Single-clock show-ahead sample FIFO with occupancy count.
// Pushes to a full FIFO are ignored; pops of an empty FIFO are ignored.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign level     = r_cnt;
  assign dout      = r_mem[r_rd];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_do_push)
                     - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Samples the synth wave at the codec rate and feeds mono samples to the audio controller.
// Define AUDIO_FEEDER_VOLUME_EN to add the 3-bit volume attenuation input.
module audio_sample_feeder
  import audio_feeder_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int SAMPLE_HZ  = SAMPLE_HZ_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FIFO_DEPTH = 8,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [IN_W-1:0]  wave_in,
`ifdef AUDIO_FEEDER_VOLUME_EN
  input  logic [2:0]       volume,
`endif
  input  logic             audio_out_allowed,
  output logic             write_audio_out,
  output logic [OUT_W-1:0] left_channel_audio_out,
  output logic [OUT_W-1:0] right_channel_audio_out,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0]    r_cnt;
  logic             w_wrap;
  logic             w_tick;
  logic             r_push;
  logic [OUT_W-1:0] r_sample;
  logic [OUT_W-1:0] r_last;
  logic             r_ovf;
  logic [2:0]       w_vol;
  logic [OUT_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_write;
  state_t           r_state;
  state_t           w_next;

`ifdef AUDIO_FEEDER_VOLUME_EN
  assign w_vol = volume;
`else
  assign w_vol = 3'd7;
`endif

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign w_tick = w_wrap & enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_push   <= 1'b0;
      r_sample <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_push <= w_tick;
      if (w_tick)
        r_sample <= OUT_W'(to_sample(16'(wave_in),
                                     w_vol, IN_W, OUT_W));
      if (r_push & w_full) r_ovf <= 1'b1;
    end
  end

  sample_fifo #(
    .DATA_W (OUT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_push),
    .pop   (w_pop),
    .din   (r_sample),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= '0;
    end else begin
      r_state <= w_next;
      if (w_write) r_last <= w_head;
    end
  end

  // The GAP cycle lets the controller refresh audio_out_allowed.
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_write = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && audio_out_allowed)
          w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_write = 1'b1;
        w_pop   = 1'b1;
        w_next  = ST_GAP;
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign write_audio_out         = w_write;
  assign left_channel_audio_out  = w_write ? w_head : r_last;
  assign right_channel_audio_out = w_write ? w_head : r_last;
  assign overflow                = r_ovf;

endmodule
